imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart to the CPU's instruction fetch path.
- Receives a program image as a byte stream over a valid/ready handshake, packs the bytes into 32-bit words and writes them into instruction memory at byte addresses 0, 4, 8, ….
- Holds the CPU in reset until the whole image has loaded and its checksum has verified.
- Sits between the host byte link (UART receiver) and the instruction memory write port / CPU reset.

Parameters:
- ADDR_W, 8: width of the word index; instruction memory depth is 2**ADDR_W words.
- MAX_WORDS, 256: largest accepted image length in words; must be ≤ 2**ADDR_W.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; a byte transfers when rx_valid && rx_ready.
- wr_en  out  1  instruction memory write strobe, one-cycle pulse.
- wr_addr  out  32  byte address of the write, equal to word_idx*4.
- wr_data  out  32  packed word, big-endian: first byte received goes to [31:24].
- cpu_hold  out  1  drives CPU reset; 1 while no verified image is present.
- done  out  1  image loaded and checksum correct.
- error  out  1  load aborted on a length or checksum fault.
- loaded_words  out  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Image format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N×4 data bytes.
  - One CSUM byte, equal to the XOR of every byte from LEN_HI through the last data byte.
- Reset values: state IDLE, rx_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=1, done=0, error=0, loaded_words=0, byte counter 0, checksum accumulator 0.
- States and transitions:
  - IDLE: start → LEN_HI; clear checksum, word index and byte counter.
  - LEN_HI: on handshake, latch the high length byte → LEN_LO.
  - LEN_LO: on handshake, evaluate N:
    - N > MAX_WORDS → ERR.
    - N == 0 → CSUM.
    - otherwise → DATA.
  - DATA: on each handshake, shift the byte into the packer and advance the byte counter (0..3).
    - On the 4th byte: on the next edge wr_en=1 for exactly one cycle, wr_addr=idx*4, wr_data=the packed word; idx and loaded_words increment in that same cycle.
    - After the N-th word is accepted → CSUM.
  - CSUM: on handshake, byte == accumulator → DONE, else → ERR.
  - DONE: done=1, cpu_hold=0. start → LEN_HI, with done cleared, cpu_hold=1 and loaded_words=0 on the same edge.
  - ERR: error=1, cpu_hold=1. start → LEN_HI, with error cleared.
- rx_ready is 1 exactly in LEN_HI, LEN_LO, DATA and CSUM, and is combinational from state. No backpressure: a byte can be accepted in the same cycle that wr_en pulses.
- Checksum accumulator XORs each byte as it is accepted, in LEN_HI, LEN_LO and DATA; the CSUM byte itself is not accumulated.
- start while in LEN_HI..CSUM is ignored. rx_valid while rx_ready=0 is ignored and no byte is consumed.
- Word index wraps modulo 2**ADDR_W internally. The MAX_WORDS check guarantees that no wrap occurs in legal use.
- Reset mid-load: return to IDLE with reset values; any partial word is discarded; memory contents already written are left unchanged.
- Throughput: one byte per cycle; a write pulse follows the 4th byte handshake by 1 cycle.

Decomposition:
- Shared include (loader_defs.vh) holds:
  - state encodings: IDLE=0, LEN_HI=1, LEN_LO=2, DATA=3, CSUM=4, DONE=5, ERR=6;
  - the byte-per-word constant (4).
- One sub-module, word_packer, owns the byte counter and the 32-bit shift register.
  - Inputs: byte and accept.
  - Outputs: word and word_ready (1-cycle).
- The FSM, checksum and address logic stay in imem_loader.

Test Plan:
- Reset, then start; send 00 02 | 20 08 00 05 | 00 00 00 00 | CSUM=0x2F → two wr_en pulses: (addr 0, 0x20080005) and (addr 4, 0x00000000); then done=1, cpu_hold=0, loaded_words=2.
- Same image with CSUM=0x2E → no done; error=1, cpu_hold=1 after the CSUM byte.
- Length 01 01 (257 > 256) → ERR on the edge after LEN_LO is accepted; no wr_en ever pulses.
- Length 00 00 followed by CSUM=0x00 → DONE with loaded_words=0 and no writes.
- rx_valid toggled 1,0,1,0 through a 4-byte word → rx_data is sampled only on the valid cycles; a single wr_en fires with the correct word.
- reset asserted after 2 data bytes, then start and a fresh 1-word image → outputs return to reset values; the new word is written at addr 0 with no stale bytes.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM state encoding and
// the packing geometry.
package imem_loader_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned LenWidth     = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenHi = 3'd1,
    StLenLo = 3'd2,
    StData  = 3'd3,
    StCsum  = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes big-endian into 32-bit words; word_ready pulses for one
// cycle after the fourth byte of a word has been accepted.
module imem_loader_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  rx_byte,
  output logic [31:0] word,
  output logic        word_ready,
  output logic [1:0]  byte_cnt
);

  localparam logic [1:0] LastByte = 2'(BytesPerWord - 1);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shift_q, shift_d;
  logic        ready_q, ready_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ready_d = 1'b0;
    if (clear) begin
      // A fresh load must never see bytes left over from an aborted one.
      cnt_d   = '0;
      shift_d = '0;
    end else if (accept) begin
      shift_d = {shift_q[23:0], rx_byte};
      cnt_d   = cnt_q + 2'd1;
      ready_d = (cnt_q == LastByte);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ready_q <= ready_d;
    end
  end

  assign word       = shift_q;
  assign word_ready = ready_q;
  assign byte_cnt   = cnt_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image from a byte stream into
// instruction memory and holds the CPU in reset until the image verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   loaded_words
);

  localparam logic [ADDR_W-1:0] IdxOne    = 1;
  localparam logic [ADDR_W:0]   LoadedOne = 1;
  localparam logic [1:0]        LastByte  = 2'(BytesPerWord - 1);

  state_e                state_q, state_d;
  logic [7:0]            csum_q, csum_d;
  logic [LenWidth-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]     idx_q, idx_d;
  logic [ADDR_W:0]       loaded_q, loaded_d;

  logic                  handshake;
  logic                  packer_clear;
  logic                  word_ready;
  logic [31:0]           word;
  logic [1:0]            byte_cnt;
  logic [LenWidth-1:0]   len_full;
  logic                  last_word;

  assign rx_ready  = (state_q == StLenHi) || (state_q == StLenLo) ||
                     (state_q == StData)  || (state_q == StCsum);
  assign handshake = rx_valid && rx_ready;
  assign len_full  = {len_q[LenWidth-1:8], rx_data};
  // loaded_q lags by at most one word, which is always complete before the
  // fourth byte of the next word arrives.
  assign last_word = (byte_cnt == LastByte) &&
                     (LenWidth'(loaded_q) == len_q - LenWidth'(1));

  imem_loader_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (packer_clear),
    .accept     (handshake && (state_q == StData)),
    .rx_byte    (rx_data),
    .word       (word),
    .word_ready (word_ready),
    .byte_cnt   (byte_cnt)
  );

  always_comb begin
    state_d      = state_q;
    csum_d       = csum_q;
    len_d        = len_q;
    idx_d        = idx_q;
    loaded_d     = loaded_q;
    packer_clear = 1'b0;

    if (word_ready) begin
      idx_d    = idx_q + IdxOne;
      loaded_d = loaded_q + LoadedOne;
    end

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StLenHi;
          csum_d       = '0;
          len_d        = '0;
          idx_d        = '0;
          loaded_d     = '0;
          packer_clear = 1'b1;
        end
      end
      StLenHi: begin
        if (handshake) begin
          len_d   = {rx_data, 8'h00};
          csum_d  = csum_q ^ rx_data;
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (handshake) begin
          len_d  = len_full;
          csum_d = csum_q ^ rx_data;
          if (32'(len_full) > MAX_WORDS) begin
            state_d = StErr;
          end else if (len_full == '0) begin
            state_d = StCsum;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (handshake) begin
          csum_d = csum_q ^ rx_data;
          if (last_word) begin
            state_d = StCsum;
          end
        end
      end
      StCsum: begin
        if (handshake) begin
          state_d = (rx_data == csum_q) ? StDone : StErr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      csum_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      loaded_q <= '0;
    end else begin
      state_q  <= state_d;
      csum_q   <= csum_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      loaded_q <= loaded_d;
    end
  end

  assign wr_en        = word_ready;
  assign wr_addr      = 32'({idx_q, 2'b00});
  assign wr_data      = word;
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);
  assign cpu_hold     = (state_q != StDone);
  assign loaded_words = loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a byte-image reference
// model that predicts writes, final status and word count.
module tb_imem_loader;

  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned MAX_WORDS = 256;

  typedef logic [7:0] bytes_t[$];

  logic              clock;
  logic              reset;
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              wr_en;
  logic [31:0]       wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   loaded_words;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .loaded_words (loaded_words)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Every write pulse must match the next write the model predicted.
  always @(negedge clock) begin
    if (!reset && wr_en) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_wr", 32'(wr_en), 32'd0);
      end else begin
        check("wr_addr", wr_addr, exp_addr_q.pop_front());
        check("wr_data", wr_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      @(posedge clock); #1;
    end
    start    = 1'b0;
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 20) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(posedge clock); #1;
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  function automatic bytes_t make_image(input int n, input bit bad);
    bytes_t img;
    logic [7:0] acc;
    img.push_back(8'(n >> 8));
    img.push_back(8'(n));
    if (n > int'(MAX_WORDS)) return img;
    for (int i = 0; i < 4 * n; i++) img.push_back(8'($urandom));
    acc = 8'h00;
    foreach (img[i]) acc ^= img[i];
    if (bad) acc ^= 8'($urandom_range(1, 255));
    img.push_back(acc);
    return img;
  endfunction

  task automatic run_image(input bytes_t img, input int min_gap, input int max_gap);
    int n;
    int consumed;
    int exp_words;
    bit exp_done;
    logic [7:0] acc;
    n = int'({img[0], img[1]});
    if (n > int'(MAX_WORDS)) begin
      consumed  = 2;
      exp_done  = 1'b0;
      exp_words = 0;
    end else begin
      consumed = 3 + 4 * n;
      acc = 8'h00;
      for (int i = 0; i < 2 + 4 * n; i++) acc ^= img[i];
      exp_done  = (img[2 + 4 * n] == acc);
      exp_words = n;
      for (int w = 0; w < n; w++) begin
        exp_addr_q.push_back(32'(4 * w));
        exp_data_q.push_back({img[2 + 4 * w], img[3 + 4 * w], img[4 + 4 * w], img[5 + 4 * w]});
      end
    end
    pulse_start();
    @(negedge clock);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_error", 32'(error), 32'd0);
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_loaded", 32'(loaded_words), 32'd0);
    for (int i = 0; i < consumed; i++) send_byte(img[i], $urandom_range(min_gap, max_gap));
    repeat (2) @(negedge clock);
    check("end_done", 32'(done), 32'(exp_done));
    check("end_error", 32'(error), 32'(!exp_done));
    check("end_hold", 32'(cpu_hold), 32'(!exp_done));
    check("end_loaded", 32'(loaded_words), 32'(exp_words));
    check("end_rx_ready", 32'(rx_ready), 32'd0);
    check("end_pending_wr", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
    check({pfx, "_wr_addr"}, wr_addr, 32'd0);
    check({pfx, "_wr_data"}, wr_data, 32'd0);
    check({pfx, "_hold"}, 32'(cpu_hold), 32'd1);
    check({pfx, "_done"}, 32'(done), 32'd0);
    check({pfx, "_error"}, 32'(error), 32'd0);
    check({pfx, "_loaded"}, 32'(loaded_words), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bytes_t img;
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_reset_values("reset");

    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2F};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h2E};
    run_image(img, 0, 0);
    img = '{8'h01, 8'h01};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h00, 8'h00};
    run_image(img, 0, 0);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};
    img[6] = 8'h01 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF;
    run_image(img, 1, 1);

    // Abort mid-word with reset, then load a fresh single-word image.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check_reset_values("midreset");
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00};
    img[6] = 8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
    run_image(img, 0, 0);

    for (int it = 0; it < 25; it++) begin
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 65535)) : int'($urandom_range(0, 6));
      img = make_image(n, $urandom_range(0, 3) == 0);
      run_image(img, 0, 2);
    end

    run_image(make_image(int'(MAX_WORDS), 1'b0), 0, 0);
    run_image(make_image(int'(MAX_WORDS) + 1, 1'b0), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
